// File: rtl/fpga_ram_pkg.sv
// Shared types and constants for the FPGA L2 RAM bank initiator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fpga_ram_pkg;

  localparam int RAM_DATA_WIDTH = 32;
  localparam int RAM_BE_WIDTH   = 4;

  // One buffered response: read data (zero for writes) and the write flag.
  typedef struct packed {
    logic [RAM_DATA_WIDTH-1:0] rdata;
    logic                      we;
  } ram_rsp_t;

  // Build a response; writes never carry data back.
  function automatic ram_rsp_t make_rsp(input logic we, input logic [RAM_DATA_WIDTH-1:0] rdata);
    ram_rsp_t r;
    r.we    = we;
    r.rdata = we ? '0 : rdata;
    return r;
  endfunction

endpackage

// File: rtl/fpga_ram_resp_fifo.sv
// Synchronous FIFO of ram_rsp_t used to park responses the consumer is not taking.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module fpga_ram_resp_fifo
  import fpga_ram_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  ram_rsp_t         push_dat_i,
  input  logic             pop_i,
  output ram_rsp_t         pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  ram_rsp_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  // Next-state for pointers and occupancy; simultaneous push/pop keeps count.
  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count state; reset discards any buffered entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/fpga_ram_bank_initiator.sv
// Drives one 32-bit L2 RAM bank port from a valid/ready request stream, returns in-order responses.
// Latency: response valid the cycle after accept (bank read data falls through, no extra stage).
// Backpressure: credit-based; req_ready drops once buffered + in-flight responses reach RESP_DEPTH.
module fpga_ram_bank_initiator
  import fpga_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int RESP_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [RAM_BE_WIDTH-1:0]   req_be_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [RAM_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_we_o,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [RAM_BE_WIDTH-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [RAM_DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic             accept;
  logic             inflight_q, inflight_d;
  logic             inflight_we_q, inflight_we_d;
  ram_rsp_t         inflight_rsp;
  ram_rsp_t         fifo_head;
  ram_rsp_t         rsp_head;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   outstanding;

  // Credits cover both buffered and in-flight responses, so the bank's read
  // data always has a FIFO slot. Gating with rst_ni idles the bank pins the
  // moment reset asserts, even mid-accept.
  assign outstanding = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
  assign req_ready_o = rst_ni & ~fifo_full & (outstanding < (CNT_W + 1)'(RESP_DEPTH));
  assign accept      = req_valid_i & req_ready_o;

  // The bank returns read data one cycle after the access; remember that one is due.
  always_comb begin
    inflight_d    = accept;
    inflight_we_d = accept & req_we_i;
  end

  // In-flight marker for the access issued last cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_we_q <= inflight_we_d;
    end
  end

  assign inflight_rsp = make_rsp(inflight_we_q, mem_rdata_i);

  // Older buffered responses go first; otherwise the bank data falls straight through.
  always_comb begin
    rsp_head = '0;
    if (!fifo_empty) begin
      rsp_head = fifo_head;
    end else if (inflight_q) begin
      rsp_head = inflight_rsp;
    end
  end

  assign rsp_valid_o = inflight_q | ~fifo_empty;
  assign rsp_rdata_o = rsp_head.rdata;
  assign rsp_we_o    = rsp_head.we;

  // The in-flight response is parked unless it was consumed directly this cycle.
  assign fifo_pop  = rsp_ready_i & ~fifo_empty;
  assign fifo_push = inflight_q & ~(fifo_empty & rsp_ready_i);

  fpga_ram_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (fifo_push),
    .push_dat_i(inflight_rsp),
    .pop_i     (fifo_pop),
    .pop_dat_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Bank pins: active only in the accepting cycle, otherwise parked idle with zeros.
  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (accept) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = ~req_we_i;
      mem_be_o    = req_we_i ? req_be_i : {RAM_BE_WIDTH{1'b1}};
      mem_addr_o  = req_addr_i;
      mem_wdata_o = req_wdata_i;
    end
  end

endmodule

// File: tb/tb_fpga_ram_bank_initiator.sv
// Bench for fpga_ram_bank_initiator: a behavioural bank, and a reference model
// that keeps an ordered list of expected responses built from request semantics.
module tb_fpga_ram_bank_initiator;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic [31:0] rdata;
    logic        we;
    logic        csn;
    logic        wen;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_be;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic        mem_csn, mem_wen;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] bank_mem [4096];
  logic [31:0] ref_mem  [4096];
  logic [32:0] exp_q [$];

  fpga_ram_bank_initiator #(.ADDR_WIDTH(12), .RESP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_we_o(rsp_we),
    .mem_csn_o(mem_csn), .mem_wen_o(mem_wen), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM bank: byte-masked writes, registered read data.
  always @(posedge clk) begin
    if (mem_csn === 1'b0) begin
      if (mem_wen === 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) bank_mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= bank_mem[mem_addr];
      end
    end
  end

  // One clock of stimulus: entered #1 after a rising edge, samples at the falling
  // edge, advances the reference model, returns #1 after the next rising edge.
  task automatic drive_cycle(input logic v, input logic w, input logic [3:0] be,
                             input logic [11:0] a, input logic [31:0] d, input logic rr,
                             output obs_t o, output obs_t e, output bit acc);
    req_valid = v; req_we = w; req_be = be; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    o = '{req_ready, rsp_valid, rsp_rdata, rsp_we, mem_csn, mem_wen, mem_be, mem_addr, mem_wdata};
    e.rdy   = (exp_q.size() < DEPTH);
    e.vld   = (exp_q.size() != 0);
    e.rdata = e.vld ? exp_q[0][31:0] : 32'h0;
    e.we    = e.vld ? exp_q[0][32] : 1'b0;
    if (!e.vld) begin
      o.rdata = 32'h0;
      o.we    = 1'b0;
    end
    acc     = v && e.rdy;
    e.csn   = !acc;
    e.wen   = !(acc && w);
    e.be    = acc ? (w ? be : 4'hF) : 4'h0;
    e.addr  = acc ? a : 12'h0;
    e.wdata = acc ? d : 32'h0;
    if (rr && e.vld) void'(exp_q.pop_front());
    if (acc) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        exp_q.push_back({1'b1, 32'h0});
      end else begin
        exp_q.push_back({1'b0, ref_mem[a]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 12'h123;
    req_wdata = 32'h55AA55AA; rsp_ready = 1'b1;
    #3;
    total++; if (mem_csn !== 1'b1) begin bad++; $display("FAIL rst_csn_in_reset got=%b want=1", mem_csn); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_vld_in_reset got=%b want=0", rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    total++; if ({rsp_rdata, rsp_we} !== 33'h0) begin bad++; $display("FAIL rst_rsp_fields got=%h want=0", {rsp_rdata, rsp_we}); end
    total++; if ({mem_csn, mem_wen} !== 2'b11) begin bad++; $display("FAIL rst_csn_wen got=%b want=11", {mem_csn, mem_wen}); end
    total++; if ({mem_be, mem_addr, mem_wdata} !== 48'h0) begin bad++; $display("FAIL rst_pins got=%h want=0", {mem_be, mem_addr, mem_wdata}); end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    obs_t o, e; bit acc;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      drive_cycle(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, o, e, acc);
      total++; if (o !== e) begin bad++; $display("FAIL %s_drain c%0d got=%h want=%h", name, i, o, e); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL %s_drain_timeout left=%0d want=0", name, exp_q.size()); end
  endtask

  task automatic test_write_read();
    obs_t o, e; bit acc;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive_cycle(1'b1, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF, 1'b1, o, e, acc);
        1: drive_cycle(1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 1'b1, o, e, acc);
        default: drive_cycle(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, o, e, acc);
      endcase
      total++; if (o !== e) begin bad++; $display("FAIL wr_rd c%0d got=%h want=%h", i, o, e); end
      if (i == 0) begin
        total++; if ({o.csn, o.wen} !== 2'b00) begin bad++; $display("FAIL wr_rd_pins got=%b want=00", {o.csn, o.wen}); end
      end
      if (i == 1) begin
        total++; if ({o.vld, o.we, o.rdata} !== {2'b11, 32'h0}) begin bad++; $display("FAIL wr_rd_wrsp got=%h want=%h", {o.vld, o.we, o.rdata}, {2'b11, 32'h0}); end
      end
      if (i == 2) begin
        total++; if ({o.vld, o.rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_rd_rdata got=%h want=1deadbeef", {o.vld, o.rdata}); end
      end
    end
  endtask

  task automatic test_partial_write();
    obs_t o, e; bit acc;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive_cycle(1'b1, 1'b1, 4'hF, 12'h020, 32'h11223344, 1'b1, o, e, acc);
        1: drive_cycle(1'b1, 1'b1, 4'b0101, 12'h020, 32'hAABBCCDD, 1'b1, o, e, acc);
        2: drive_cycle(1'b1, 1'b0, 4'h0, 12'h020, 32'h0, 1'b1, o, e, acc);
        default: drive_cycle(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, o, e, acc);
      endcase
      total++; if (o !== e) begin bad++; $display("FAIL partial c%0d got=%h want=%h", i, o, e); end
      if (i == 3) begin
        total++; if (o.rdata !== 32'h11BB33DD) begin bad++; $display("FAIL partial_rdata got=%h want=11bb33dd", o.rdata); end
      end
    end
  endtask

  task automatic test_streaming();
    obs_t o, e; bit acc;
    int n_rsp = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < 8)       drive_cycle(1'b1, 1'b1, 4'hF, 12'(i), $urandom, 1'b1, o, e, acc);
      else if (i < 16) drive_cycle(1'b1, 1'b0, 4'h0, 12'(i - 8), 32'h0, 1'b1, o, e, acc);
      else             drive_cycle(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, o, e, acc);
      total++; if (o !== e) begin bad++; $display("FAIL stream c%0d got=%h want=%h", i, o, e); end
      if (i < 16) begin
        total++; if (o.rdy !== 1'b1) begin bad++; $display("FAIL stream_ready c%0d got=%b want=1", i, o.rdy); end
      end
      if (o.vld === 1'b1) n_rsp++;
    end
    total++; if (n_rsp != 16) begin bad++; $display("FAIL stream_count got=%0d want=16", n_rsp); end
  endtask

  task automatic test_backpressure();
    obs_t o, e; bit acc;
    int idx = 0;
    int acc_at_stall = -1;
    for (int i = 0; i < 40 && !(idx == 5 && exp_q.size() == 0); i++) begin
      drive_cycle(idx < 5, 1'b0, 4'h0, 12'(idx), 32'h0, i >= 5, o, e, acc);
      if (acc) idx++;
      total++; if (o !== e) begin bad++; $display("FAIL bp c%0d got=%h want=%h", i, o, e); end
      if (i == 2) begin
        total++; if (o.rdy !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b want=0", o.rdy); end
      end
      if (i == 4) acc_at_stall = idx;
    end
    total++; if (acc_at_stall != DEPTH) begin bad++; $display("FAIL bp_accepts got=%0d want=%0d", acc_at_stall, DEPTH); end
    total++; if (idx != 5) begin bad++; $display("FAIL bp_complete got=%0d want=5", idx); end
  endtask

  task automatic test_simul_push_pop();
    obs_t o, e; bit acc;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive_cycle(1'b1, 1'b0, 4'h0, 12'h003, 32'h0, 1'b0, o, e, acc);
        1: drive_cycle(1'b1, 1'b0, 4'h0, 12'h005, 32'h0, 1'b0, o, e, acc);
        default: drive_cycle(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, o, e, acc);
      endcase
      total++; if (o !== e) begin bad++; $display("FAIL simul c%0d got=%h want=%h", i, o, e); end
      if (i == 3) begin
        total++; if ({o.vld, o.rdata} !== {1'b1, ref_mem[5]}) begin bad++; $display("FAIL simul_second got=%h want=%h", {o.vld, o.rdata}, {1'b1, ref_mem[5]}); end
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e; bit acc;
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 12'($urandom_range(0, 15)),
                  $urandom, 1'($urandom_range(0, 2) != 0), o, e, acc);
      total++; if (o !== e) begin bad++; $display("FAIL random c%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e; bit acc;
    drive_cycle(1'b1, 1'b0, 4'h0, 12'h001, 32'h0, 1'b0, o, e, acc);
    drive_cycle(1'b1, 1'b0, 4'h0, 12'h002, 32'h0, 1'b0, o, e, acc);
    drive_cycle(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0, o, e, acc);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rmid_buffered got=%b want=1", rsp_valid); end
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 12'h001; req_wdata = 32'hBADBAD00;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", rsp_valid); end
    total++; if (mem_csn !== 1'b1) begin bad++; $display("FAIL rmid_csn got=%b want=1", mem_csn); end
    req_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", req_ready); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) drive_cycle(1'b1, 1'b0, 4'h0, 12'h002, 32'h0, 1'b1, o, e, acc);
      else        drive_cycle(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, o, e, acc);
      total++; if (o !== e) begin bad++; $display("FAIL rmid_after c%0d got=%h want=%h", i, o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      bank_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    mem_rdata = 32'h0;
    test_reset();
    test_write_read();
    drain("wr_rd");
    test_partial_write();
    drain("partial");
    test_streaming();
    drain("stream");
    test_backpressure();
    drain("bp");
    test_simul_push_pop();
    drain("simul");
    test_random();
    drain("random");
    test_reset_mid();
    drain("rmid");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
